meio_somador_2: RTL and testbench
=================================

# meio_somador_2

Single-bit half adder with a registered shadow and an optional event-statistics block. The combinational core gives sum (a1 XOR a2) and carry (a1 AND a2) with zero latency. Registered copies of both outputs serve clocked consumers. It is the leaf arithmetic cell in the lab adder hierarchy and is instantiated by full-adder and ripple-adder wrappers.

## Interface
Parameters:
- CNT_W, default 8: width of the statistics counters, legal range 2..32.

Ports are listed clock and reset first. Declaration order is a1, a2, soma, cout, clk, rst, then the rest, so positional instantiation of the first four ports works.
- clk  input  1  single clock; every register updates on its rising edge.
- rst  input  1  reset, synchronous, active-high; sampled on the clk rising edge.
- a1  input  1  addend A.
- a2  input  1  addend B.
- soma  output  1  combinational sum, a1 ^ a2.
- cout  output  1  combinational carry, a1 & a2.
- soma_q  output  1  soma registered one clock later.
- cout_q  output  1  cout registered one clock later.
- clr  input  1  synchronous clear of the statistics counters only.
- carry_cnt  output  CNT_W  number of clock edges sampled with cout=1; saturating.
- sum_cnt  output  CNT_W  number of clock edges sampled with soma=1; saturating.
- sat  output  1  high while either counter equals its all-ones value.

## Operation
- soma and cout depend only on a1 and a2. They are purely combinational and never depend on clk, rst or clr.
- Truth table as (a1, a2 -> soma, cout): 00->0,0; 01->1,0; 10->1,0; 11->0,1. soma and cout are never both 1.
- soma_q and cout_q load soma and cout on every non-reset rising edge.
- Statistics counter update rule (CNT_W-bit, unsigned):
  - Each rising edge with rst=0 and clr=0: carry_cnt increments if cout=1, and sum_cnt increments if soma=1.
  - A counter at all-ones holds its value. It never wraps to 0.
- clr=1 with rst=0: both counters load 0 on that edge. Any increment on the same edge is discarded, so clr wins. soma_q and cout_q still load normally.
- rst=1: soma_q, cout_q, carry_cnt and sum_cnt all load 0. rst has priority over clr and over any increment.
- sat = (carry_cnt == all-ones) | (sum_cnt == all-ones). It is combinational from the counter registers.
- X or Z on a1 or a2 is not supported. Behaviour is undefined and no checking is done.

## Timing
- soma and cout: zero-cycle latency, settle within one propagation delay of an input change. No clock is required; the block is usable with clk tied low.
- soma_q and cout_q: exactly 1-cycle latency from the inputs sampled at a rising edge.
- Counters reflect an edge's inputs immediately after that edge, giving 1-cycle latency.
- Reset values: soma_q=0, cout_q=0, carry_cnt=0, sum_cnt=0, sat=0. soma and cout follow the inputs even during reset.
- Reset asserted mid-operation: registers clear on the next rising edge. Counting resumes on the first edge with rst=0.
- Before the first reset edge, register contents are undefined.

## Configuration
- Macro MEIO_SOMADOR_STATS_EN controls the statistics block.
- Defined: carry_cnt, sum_cnt, sat and clr are implemented as described above.
- Undefined: the counter logic is compiled out. carry_cnt and sum_cnt are tied to 0 and sat is tied to 0. clr remains a port but is ignored.
- soma, cout, soma_q and cout_q are present and identical in both builds.

## Test plan
- Combinational sweep with no clock. Drive a1,a2 = 00, 01, 10, 11, holding each for 1 time unit. Required soma,cout = 0,0 / 1,0 / 1,0 / 0,1.
- Registered path: after reset, apply a1=1, a2=1, then one clk edge. Required soma_q=0 and cout_q=1, while soma and cout are already 0,1 before the edge.
- Counting (STATS_EN, CNT_W=8): reset, then hold 11 for 3 edges and 01 for 2 edges. Required carry_cnt=3, sum_cnt=2, sat=0.
- Saturation (STATS_EN, CNT_W=2): hold 11 for 5 edges. Required carry_cnt=3 with no wrap, sat=1, sum_cnt=0.
- Priority: with carry_cnt=2, drive rst=1 and clr=1 together with 11 for one edge. Required: all counters 0, soma_q=0, cout_q=0. Then clr=1 alone with 11: counters stay 0 and cout_q=1.
- Build without MEIO_SOMADOR_STATS_EN: any stimulus gives carry_cnt=0, sum_cnt=0, sat=0, and soma and cout behave as in the first scenario.

Source files
------------

// File: rtl/meio_somador_2.sv
// Single-bit half adder with a registered shadow of sum/carry and optional
// saturating event counters, enabled by defining MEIO_SOMADOR_STATS_EN.
module meio_somador_2 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             a1,
  input  logic             a2,
  output logic             soma,
  output logic             cout,
  input  logic             clk,
  input  logic             rst,
  output logic             soma_q,
  output logic             cout_q,
  input  logic             clr,
  output logic [CNT_W-1:0] carry_cnt,
  output logic [CNT_W-1:0] sum_cnt,
  output logic             sat
);

  // The combinational core stays clock-free so the cell also works with clk tied low.
  assign soma = a1 ^ a2;
  assign cout = a1 & a2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset here is synchronous, hence no rst in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      soma_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      soma_q <= soma;
      cout_q <= cout;
    end
  end

`ifdef MEIO_SOMADOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic carry_full;
  logic sum_full;

  assign carry_full = (carry_cnt == CNT_MAX);
  assign sum_full   = (sum_cnt == CNT_MAX);

  // Priority is rst, then clr, then increment; a full counter holds instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt <= '0;
      sum_cnt   <= '0;
    end else if (clr) begin
      carry_cnt <= '0;
      sum_cnt   <= '0;
    end else begin
      if (cout && !carry_full) carry_cnt <= carry_cnt + CNT_ONE;
      if (soma && !sum_full)   sum_cnt   <= sum_cnt + CNT_ONE;
    end
  end

  assign sat = carry_full | sum_full;
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign carry_cnt  = '0;
  assign sum_cnt    = '0;
  assign sat        = 1'b0;
`endif

endmodule

// File: tb/tb_meio_somador_2.sv
// Directed self-checking bench for meio_somador_2; runs in both builds
// (with or without MEIO_SOMADOR_STATS_EN), using a CNT_W=8 and a CNT_W=2 instance.
`timescale 1ns/1ps
module tb_meio_somador_2;

`ifdef MEIO_SOMADOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       a1 = 1'b0;
  logic       a2 = 1'b0;

  logic       soma8, cout8, soma_q8, cout_q8, sat8;
  logic [7:0] carry_cnt8, sum_cnt8;
  logic       soma2, cout2, soma_q2, cout_q2, sat2;
  logic [1:0] carry_cnt2, sum_cnt2;

  int checks = 0;
  int fails  = 0;

  meio_somador_2 #(.CNT_W(8)) dut8 (
    .a1(a1), .a2(a2), .soma(soma8), .cout(cout8), .clk(clk), .rst(rst),
    .soma_q(soma_q8), .cout_q(cout_q8), .clr(clr),
    .carry_cnt(carry_cnt8), .sum_cnt(sum_cnt8), .sat(sat8)
  );

  meio_somador_2 #(.CNT_W(2)) dut2 (
    .a1(a1), .a2(a2), .soma(soma2), .cout(cout2), .clk(clk), .rst(rst),
    .soma_q(soma_q2), .cout_q(cout_q2), .clr(clr),
    .carry_cnt(carry_cnt2), .sum_cnt(sum_cnt2), .sat(sat2)
  );

  // Clock stays low until enabled, so the first scenario runs with no clock at all.
  initial forever #5 clk = clk_en ? ~clk : 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; a1 = 1'b0; a2 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_comb_sweep();
    logic [1:0] vec;
    logic exp_s, exp_c;
    for (int i = 0; i < 4; i++) begin
      vec = i[1:0];
      a1 = vec[1]; a2 = vec[0];
      #1;
      exp_s = (i == 1 || i == 2);
      exp_c = (i == 3);
      checks++;
      if (soma8 !== exp_s || cout8 !== exp_c || soma2 !== exp_s || cout2 !== exp_c) begin
        $display("FAIL comb_sweep a1a2=%b got soma,cout=%b%b/%b%b exp %b%b",
                 vec, soma8, cout8, soma2, cout2, exp_s, exp_c);
        fails++;
      end
    end
  endtask

  task automatic test_reset();
    a1 = 1'b1; a2 = 1'b1; rst = 1'b1; clr = 1'b0;
    tick();
    checks++;
    if (soma_q8 !== 1'b0 || cout_q8 !== 1'b0 || carry_cnt8 !== 8'd0 || sum_cnt8 !== 8'd0 || sat8 !== 1'b0) begin
      $display("FAIL reset_state got soma_q=%b cout_q=%b carry=%0d sum=%0d sat=%b exp all 0",
               soma_q8, cout_q8, carry_cnt8, sum_cnt8, sat8);
      fails++;
    end
    checks++;
    if (soma8 !== 1'b0 || cout8 !== 1'b1) begin
      $display("FAIL reset_comb_follow got soma=%b cout=%b exp 0 1", soma8, cout8);
      fails++;
    end
    rst = 1'b0;
  endtask

  task automatic test_registered();
    do_reset();
    a1 = 1'b1; a2 = 1'b1;
    #1;
    checks++;
    if (soma8 !== 1'b0 || cout8 !== 1'b1 || soma_q8 !== 1'b0 || cout_q8 !== 1'b0) begin
      $display("FAIL registered_pre_edge got soma=%b cout=%b soma_q=%b cout_q=%b exp 0 1 0 0",
               soma8, cout8, soma_q8, cout_q8);
      fails++;
    end
    tick();
    checks++;
    if (soma_q8 !== 1'b0 || cout_q8 !== 1'b1 || soma_q2 !== 1'b0 || cout_q2 !== 1'b1) begin
      $display("FAIL registered_post_edge got soma_q=%b cout_q=%b exp 0 1", soma_q8, cout_q8);
      fails++;
    end
  endtask

  task automatic test_counting();
    do_reset();
    a1 = 1'b1; a2 = 1'b1;
    repeat (3) tick();
    a1 = 1'b0; a2 = 1'b1;
    repeat (2) tick();
    checks++;
    if (carry_cnt8 !== (STATS ? 8'd3 : 8'd0) || sum_cnt8 !== (STATS ? 8'd2 : 8'd0) || sat8 !== 1'b0) begin
      $display("FAIL counting_w8 got carry=%0d sum=%0d sat=%b exp %0d %0d 0",
               carry_cnt8, sum_cnt8, sat8, STATS ? 3 : 0, STATS ? 2 : 0);
      fails++;
    end
    checks++;
    if (carry_cnt2 !== (STATS ? 2'd3 : 2'd0) || sum_cnt2 !== (STATS ? 2'd2 : 2'd0) || sat2 !== STATS) begin
      $display("FAIL counting_w2 got carry=%0d sum=%0d sat=%b exp %0d %0d %b",
               carry_cnt2, sum_cnt2, sat2, STATS ? 3 : 0, STATS ? 2 : 0, STATS);
      fails++;
    end
    checks++;
    if (soma_q8 !== 1'b1 || cout_q8 !== 1'b0) begin
      $display("FAIL counting_shadow got soma_q=%b cout_q=%b exp 1 0", soma_q8, cout_q8);
      fails++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    a1 = 1'b1; a2 = 1'b1;
    repeat (5) tick();
    checks++;
    if (carry_cnt2 !== (STATS ? 2'd3 : 2'd0) || sum_cnt2 !== 2'd0 || sat2 !== STATS) begin
      $display("FAIL saturation_w2 got carry=%0d sum=%0d sat=%b exp %0d 0 %b",
               carry_cnt2, sum_cnt2, sat2, STATS ? 3 : 0, STATS);
      fails++;
    end
    checks++;
    if (carry_cnt8 !== (STATS ? 8'd5 : 8'd0) || sat8 !== 1'b0) begin
      $display("FAIL saturation_w8 got carry=%0d sat=%b exp %0d 0",
               carry_cnt8, sat8, STATS ? 5 : 0);
      fails++;
    end
  endtask

  task automatic test_priority();
    do_reset();
    a1 = 1'b1; a2 = 1'b1;
    repeat (2) tick();
    checks++;
    if (carry_cnt8 !== (STATS ? 8'd2 : 8'd0)) begin
      $display("FAIL priority_setup got carry=%0d exp %0d", carry_cnt8, STATS ? 2 : 0);
      fails++;
    end
    rst = 1'b1; clr = 1'b1;
    tick();
    checks++;
    if (carry_cnt8 !== 8'd0 || sum_cnt8 !== 8'd0 || carry_cnt2 !== 2'd0 || soma_q8 !== 1'b0 || cout_q8 !== 1'b0) begin
      $display("FAIL priority_rst_clr got carry=%0d sum=%0d soma_q=%b cout_q=%b exp 0 0 0 0",
               carry_cnt8, sum_cnt8, soma_q8, cout_q8);
      fails++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (carry_cnt8 !== 8'd0 || carry_cnt2 !== 2'd0 || sat2 !== 1'b0 || soma_q8 !== 1'b0 || cout_q8 !== 1'b1) begin
      $display("FAIL priority_clr_only got carry=%0d sat2=%b soma_q=%b cout_q=%b exp 0 0 0 1",
               carry_cnt8, sat2, soma_q8, cout_q8);
      fails++;
    end
    clr = 1'b0;
    tick();
    checks++;
    if (carry_cnt8 !== (STATS ? 8'd1 : 8'd0)) begin
      $display("FAIL priority_resume got carry=%0d exp %0d", carry_cnt8, STATS ? 1 : 0);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] vecs [7];
    logic exp_s, exp_c;
    int n_sum, n_carry;
    vecs = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00};
    n_sum = 0; n_carry = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      a1 = vecs[i][1]; a2 = vecs[i][0];
      exp_s = (vecs[i] == 2'b01) || (vecs[i] == 2'b10);
      exp_c = (vecs[i] == 2'b11);
      if (exp_s) n_sum++;
      if (exp_c) n_carry++;
      tick();
      checks++;
      if (soma_q8 !== exp_s || cout_q8 !== exp_c
          || carry_cnt8 !== (STATS ? 8'(n_carry) : 8'd0)
          || sum_cnt8 !== (STATS ? 8'(n_sum) : 8'd0)
          || sum_cnt2 !== (STATS ? 2'((n_sum > 3) ? 3 : n_sum) : 2'd0)) begin
        $display("FAIL back_to_back step %0d got soma_q=%b cout_q=%b carry=%0d sum=%0d sum2=%0d exp %b %b %0d %0d",
                 i, soma_q8, cout_q8, carry_cnt8, sum_cnt8, sum_cnt2, exp_s, exp_c,
                 STATS ? n_carry : 0, STATS ? n_sum : 0);
        fails++;
      end
    end
  endtask

  initial begin
    test_comb_sweep();
    clk_en = 1'b1;
    test_reset();
    test_registered();
    test_counting();
    test_saturation();
    test_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
